// File: rtl/writeback_arbiter_if.sv
// Writeback bundle between the execution units, the scheduler and the arbiter:
// requests and results in, acknowledges, register-file write and scoreboard out.
interface writeback_arbiter_if #(
  parameter int NUNITS = 5,
  parameter int DATA_W = 64
);
  logic                     issue_valid;
  logic [5:0]               issue_rd;
  logic [5:0]               issue_rd2;
  logic                     issue_dual;
  logic [NUNITS-1:0]        wb_req;
  logic [6*NUNITS-1:0]      wb_rn;
  logic [DATA_W*NUNITS-1:0] wb_data;
  logic [5:0]               wb_rn2;
  logic [DATA_W-1:0]        wb_data2;
  logic [NUNITS-1:0]        wb_ack;
  logic                     rf_we;
  logic [5:0]               rf_wa;
  logic [DATA_W-1:0]        rf_wd;
  logic [63:0]              reg_busy;

  modport master (
    output issue_valid, issue_rd, issue_rd2, issue_dual,
    output wb_req, wb_rn, wb_data, wb_rn2, wb_data2,
    input  wb_ack, rf_we, rf_wa, rf_wd, reg_busy
  );

  modport slave (
    input  issue_valid, issue_rd, issue_rd2, issue_dual,
    input  wb_req, wb_rn, wb_data, wb_rn2, wb_data2,
    output wb_ack, rf_we, rf_wa, rf_wd, reg_busy
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter of execution-unit writebacks onto the single register-file
// write port; advint results take two beats. Also owns the register scoreboard.
module writeback_arbiter #(
  parameter int NUNITS    = 5,
  parameter int DATA_W    = 64,
  parameter int DUAL_UNIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  writeback_arbiter_if.slave wb
);

  localparam logic [2:0] DUAL_IDX = 3'(DUAL_UNIT);
  localparam logic [2:0] PTR_RST  = 3'(NUNITS - 1);

  typedef enum logic {ARB, DUAL} state_t;

  state_t              state_q, state_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [NUNITS-1:0]   elig;
  logic                found;
  logic [2:0]          win;
  logic [5:0]          sel_rn;
  logic [DATA_W-1:0]   sel_wd;
  logic [NUNITS-1:0]   sel_hot;

  logic [NUNITS-1:0]   ack_d, ack_p1;
  logic                we_d, we_p1;
  logic [5:0]          wa_d, wa_p1;
  logic [DATA_W-1:0]   wd_d, wd_p1;
  logic [63:0]         busy_d, busy_q;

  // A unit still sees its own ack this cycle, so its request is stale.
  assign elig = wb.wb_req & ~ack_p1;

  always_comb begin : rr_search
    int idx;
    found = 1'b0;
    win   = ptr_q;
    idx   = 0;
    for (int i = 1; i <= NUNITS; i++) begin
      idx = (int'(ptr_q) + i) % NUNITS;
      for (int u = 0; u < NUNITS; u++) begin
        if (!found && idx == u && elig[u]) begin
          found = 1'b1;
          win   = 3'(u);
        end
      end
    end
  end

  always_comb begin
    sel_rn  = '0;
    sel_wd  = '0;
    sel_hot = '0;
    for (int u = 0; u < NUNITS; u++) begin
      if (win == 3'(u)) begin
        sel_rn     = wb.wb_rn[6*u +: 6];
        sel_wd     = wb.wb_data[DATA_W*u +: DATA_W];
        sel_hot[u] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (found && win == DUAL_IDX) state_d = DUAL;
      DUAL:    state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // The advint ack is held back until its second beat goes out.
  always_comb begin
    ack_d = '0;
    we_d  = 1'b0;
    wa_d  = wa_p1;
    wd_d  = wd_p1;
    ptr_d = ptr_q;
    case (state_q)
      ARB: begin
        if (found) begin
          ptr_d = win;
          wa_d  = sel_rn;
          wd_d  = sel_wd;
          we_d  = |sel_rn;
          if (win != DUAL_IDX) ack_d = sel_hot;
        end
      end
      DUAL: begin
        wa_d             = wb.wb_rn2;
        wd_d             = wb.wb_data2;
        we_d             = |wb.wb_rn2;
        ack_d[DUAL_UNIT] = 1'b1;
      end
      default: ;
    endcase
  end

  // A new issue overrides a same-edge writeback clear; r0 never goes busy.
  always_comb begin
    busy_d = busy_q;
    if (we_p1) busy_d[wa_p1] = 1'b0;
    if (wb.issue_valid) begin
      busy_d[wb.issue_rd] = 1'b1;
      if (wb.issue_dual) busy_d[wb.issue_rd2] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Stage p1: registered grant, write port and scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q   <= PTR_RST;
      ack_p1  <= '0;
      we_p1   <= 1'b0;
      wa_p1   <= '0;
      wd_p1   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ack_p1  <= ack_d;
      we_p1   <= we_d;
      wa_p1   <= wa_d;
      wd_p1   <= wd_d;
      busy_q  <= busy_d;
    end
  end

  assign wb.wb_ack   = ack_p1;
  assign wb.rf_we    = we_p1;
  assign wb.rf_wa    = wa_p1;
  assign wb.rf_wd    = wd_p1;
  assign wb.reg_busy = busy_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, single writes, round-robin order,
// two-beat advint results, scoreboard set/clear rules and reset during a dual beat.
module tb_writeback_arbiter;
  localparam int NUNITS = 5;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_arbiter_if #(.NUNITS(NUNITS), .DATA_W(DATA_W)) wif ();

  writeback_arbiter #(.NUNITS(NUNITS), .DATA_W(DATA_W), .DUAL_UNIT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wif.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [NUNITS-1:0] prev_ack;
  logic              renew0;

  logic [5:0]  t3_wa  [6] = '{6'd1, 6'd2, 6'd3, 6'd6, 6'd4, 6'd5};
  logic [4:0]  t3_ack [6] = '{5'b00001, 5'b00010, 5'b00000, 5'b00100, 5'b01000, 5'b10000};
  logic [63:0] t3_wd  [6] = '{64'h100, 64'h101, 64'h102, 64'h2222, 64'h103, 64'h104};

  logic        t4_we  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [5:0]  t4_wa  [6] = '{6'd8, 6'd9, 6'd8, 6'd0, 6'd8, 6'd0};
  logic [4:0]  t4_ack [6] = '{5'b00001, 5'b00010, 5'b00001, 5'b00000, 5'b00001, 5'b00000};
  logic [63:0] t4_wd  [6] = '{64'hA0, 64'hB0, 64'hA1, 64'h0, 64'hA2, 64'h0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic exp_we, input logic [5:0] exp_wa,
                            input logic [63:0] exp_wd, input logic [4:0] exp_ack);
    check({tag, "_we"}, 64'(wif.rf_we), 64'(exp_we));
    check({tag, "_ack"}, 64'(wif.wb_ack), 64'(exp_ack));
    if (exp_we) begin
      check({tag, "_wa"}, 64'(wif.rf_wa), 64'(exp_wa));
      check({tag, "_wd"}, wif.rf_wd, exp_wd);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"}, 64'(wif.rf_we), 64'd0);
    check({tag, "_ack"}, 64'(wif.wb_ack), 64'd0);
    check({tag, "_wa"}, 64'(wif.rf_wa), 64'd0);
    check({tag, "_wd"}, wif.rf_wd, 64'd0);
    check({tag, "_busy"}, wif.reg_busy, 64'd0);
  endtask

  // Units drop (or renew) their request in the cycle after they saw an ack.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUNITS; i++) begin
      if (prev_ack[i]) begin
        if (i == 0 && renew0) wif.wb_data[DATA_W-1:0] = wif.wb_data[DATA_W-1:0] + 64'd1;
        else                  wif.wb_req[i] = 1'b0;
      end
    end
    prev_ack = wif.wb_ack;
  endtask

  task automatic set_req(input int u, input logic [5:0] rn, input logic [63:0] d);
    wif.wb_rn[6*u +: 6]           = rn;
    wif.wb_data[DATA_W*u +: DATA_W] = d;
    wif.wb_req[u]                 = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    wif.issue_valid = 1'b0;
    wif.issue_rd    = '0;
    wif.issue_rd2   = '0;
    wif.issue_dual  = 1'b0;
    wif.wb_req      = '0;
    wif.wb_rn       = '0;
    wif.wb_data     = '0;
    wif.wb_rn2      = '0;
    wif.wb_data2    = '0;
    renew0          = 1'b0;
    prev_ack        = '0;
    rst_n           = 1'b0;
    tick();
    check_zero(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    do_reset("rst1");
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("idle%0d_busy", k), wif.reg_busy, 64'd0);
      check($sformatf("idle%0d_we", k), 64'(wif.rf_we), 64'd0);
      check($sformatf("idle%0d_ack", k), 64'(wif.wb_ack), 64'd0);
    end

    // single issue then writeback of r5
    wif.issue_valid = 1'b1;
    wif.issue_rd    = 6'd5;
    tick();
    wif.issue_valid = 1'b0;
    check("t2_busy_set", wif.reg_busy, 64'h20);
    tick();
    tick();
    set_req(0, 6'd5, 64'hDEAD);
    tick();
    check_beat("t2_wb", 1'b1, 6'd5, 64'hDEAD, 5'b00001);
    check("t2_busy_hold", wif.reg_busy, 64'h20);
    tick();
    check_beat("t2_after", 1'b0, 6'd0, 64'h0, 5'b00000);
    check("t2_busy_clr", wif.reg_busy, 64'h0);

    // all five units at once
    do_reset("rst3");
    for (int u = 0; u < NUNITS; u++) set_req(u, 6'(u + 1), 64'h100 + 64'(u));
    wif.wb_rn2   = 6'd6;
    wif.wb_data2 = 64'h2222;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_beat($sformatf("t3_c%0d", k + 1), 1'b1, t3_wa[k], t3_wd[k], t3_ack[k]);
    end
    tick();
    check_beat("t3_idle", 1'b0, 6'd0, 64'h0, 5'b00000);

    // alu1 streaming against a single alu2 request
    do_reset("rst4");
    set_req(0, 6'd8, 64'hA0);
    set_req(1, 6'd9, 64'hB0);
    renew0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_beat($sformatf("t4_c%0d", k + 1), t4_we[k], t4_wa[k], t4_wd[k], t4_ack[k]);
    end
    renew0     = 1'b0;
    wif.wb_req = '0;
    tick();

    // scoreboard set-over-clear, dual issue, r0 rules
    do_reset("rst5");
    wif.issue_valid = 1'b1;
    wif.issue_rd    = 6'd7;
    tick();
    wif.issue_valid = 1'b0;
    set_req(1, 6'd7, 64'h77);
    check("t5_busy7", wif.reg_busy, 64'h80);
    tick();
    check_beat("t5_wr7", 1'b1, 6'd7, 64'h77, 5'b00010);
    wif.issue_valid = 1'b1;
    wif.issue_rd    = 6'd7;
    wif.issue_dual  = 1'b1;
    wif.issue_rd2   = 6'd9;
    tick();
    wif.issue_valid = 1'b0;
    wif.issue_dual  = 1'b0;
    check("t5_setwins", wif.reg_busy, 64'h280);
    check_beat("t5_stale", 1'b0, 6'd0, 64'h0, 5'b00000);
    set_req(0, 6'd0, 64'h55);
    tick();
    check_beat("t5_r0", 1'b0, 6'd0, 64'h0, 5'b00001);
    wif.issue_valid = 1'b1;
    wif.issue_rd    = 6'd0;
    wif.issue_dual  = 1'b1;
    wif.issue_rd2   = 6'd0;
    tick();
    wif.issue_valid = 1'b0;
    wif.issue_dual  = 1'b0;
    check("t5_busy_r0", wif.reg_busy, 64'h280);
    check_beat("t5_r0_after", 1'b0, 6'd0, 64'h0, 5'b00000);

    // reset in the middle of an advint dual result
    do_reset("rst6");
    wif.issue_valid = 1'b1;
    wif.issue_rd    = 6'd10;
    set_req(2, 6'd10, 64'hAAAA);
    wif.wb_rn2   = 6'd11;
    wif.wb_data2 = 64'hBBBB;
    tick();
    wif.issue_valid = 1'b0;
    check_beat("t6_beat1", 1'b1, 6'd10, 64'hAAAA, 5'b00000);
    check("t6_busy10", wif.reg_busy, 64'h400);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t6_async");
    set_req(0, 6'd12, 64'hC);
    tick();
    check_zero("t6_held");
    rst_n = 1'b1;
    tick();
    check_beat("t6_alu1", 1'b1, 6'd12, 64'hC, 5'b00001);
    tick();
    check_beat("t6_dual1", 1'b1, 6'd10, 64'hAAAA, 5'b00000);
    tick();
    check_beat("t6_dual2", 1'b1, 6'd11, 64'hBBBB, 5'b00100);
    tick();
    check_beat("t6_done", 1'b0, 6'd0, 64'h0, 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
